alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 88 ++++++++
 tb/tb_alu_issue_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation to a combinational ALU, captures its result, and holds the response until it is accepted.
// Define ALU_ISSUE_OPCHK_EN to flag illegal opcodes on rsp_err_o; without it rsp_err_o is tied low.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [3:0]       req_op_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_flag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_flag_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] op_count_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             flag_q, flag_d, illegal, accept, capture, done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_ISSUE_OPCHK_EN
  logic err_q, err_d;
  assign illegal = !(alu_op_q inside {4'b0000, 4'b0010, 4'b0110});
  assign err_d = capture ? illegal : err_q;
  assign rsp_err_o = err_q;
  always_ff @(posedge clk_i)
    err_q <= reset_i ? 1'b0 : err_d;
`else
  assign illegal = 1'b0;
  assign rsp_err_o = 1'b0;
`endif
  assign accept  = state_q == IDLE && req_valid_i;
  assign capture = state_q == EXEC;
  assign done    = state_q == RESP && rsp_ready_i;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = req_valid_i ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    alu_a_d  = accept ? req_a_i : alu_a_q;
    alu_b_d  = accept ? req_b_i : alu_b_q;
    alu_op_d = accept ? req_op_i : alu_op_q;
    res_d    = capture ? (illegal ? '0 : alu_result_i) : res_q;
    flag_d   = capture ? (alu_flag_i && !illegal) : flag_q;
    cnt_d    = cnt_q + CNT_W'(done);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end
  assign req_ready_o  = state_q == IDLE;
  assign rsp_valid_o  = state_q == RESP;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign rsp_result_o = res_q;
  assign rsp_flag_o   = flag_q;
  assign op_count_o   = cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed operations against a reference ALU model, checked by a queue-based scoreboard.
module tb_alu_issue_ctrl;
  localparam int W = 32, CW = 8;
  logic clk = 0, reset_i = 1, req_valid_i = 0, rsp_ready_i = 0;
  logic [W-1:0] req_a_i = 0, req_b_i = 0, alu_a_o, alu_b_o, alu_result_i, rsp_result_o;
  logic [3:0] req_op_i = 0, alu_op_o;
  logic req_ready_o, alu_flag_i, rsp_valid_o, rsp_flag_o, rsp_err_o;
  logic [CW-1:0] op_count_o;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] a, b, res;
    logic [3:0]   op;
    logic         flag, err;
    int           first, hold;
  } exp_t;
  exp_t q[$];
  logic [CW-1:0] exp_cnt = 0;

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_flag_i(alu_flag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_flag_o(rsp_flag_o), .rsp_err_o(rsp_err_o), .op_count_o(op_count_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic unit: and / add-with-carry / sub-with-borrow, anything else xor with parity flag.
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [W:0] s;
    case (op)
      4'b0000: s = {(a & b) == 0, a & b};
      4'b0010: s = {1'b0, a} + {1'b0, b};
      4'b0110: s = {a < b, a - b};
      default: s = {^(a ^ b), a ^ b};
    endcase
    return s;
  endfunction
  assign {alu_flag_i, alu_result_i} = alu_f(alu_a_o, alu_b_o, alu_op_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input int hold, input int first);
    exp_t e;
    logic [W:0] s = alu_f(a, b, op);
    e.a = a; e.b = b; e.op = op; e.res = s[W-1:0]; e.flag = s[W]; e.err = 1'b0;
    e.hold = hold; e.first = first;
`ifdef ALU_ISSUE_OPCHK_EN
    if (!(op inside {4'b0000, 4'b0010, 4'b0110})) begin e.res = 0; e.flag = 0; e.err = 1; end
`endif
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input int hold);
    int n = 0;
    while (!req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready_o) chk("issue_timeout", 64'(req_ready_o), 64'd1);
    req_valid_i = 1; req_a_i = a; req_b_i = b; req_op_i = op;
    q.push_back(mk(a, b, op, hold, cyc + 2));
    @(posedge clk); #1;
    req_valid_i = 0; req_a_i = $urandom; req_b_i = $urandom; req_op_i = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && req_ready_o) && n < 100) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [3:0] rnd_op();
    int p = $urandom_range(0, 4);
    return p == 0 ? 4'b0000 : p == 1 ? 4'b0010 : p == 2 ? 4'b0110 : p == 3 ? 4'b1111 : 4'($urandom);
  endfunction

  // Monitor and consumer: holds rsp_ready low for each entry's hold count, then takes the response.
  logic [W-1:0] last_res;
  logic last_flag, last_err;
  int age = 0;
  always @(negedge clk) begin
    if (reset_i) begin
      q.delete(); exp_cnt = 0; age = 0; rsp_ready_i = 1'($urandom);
    end else begin
      chk("op_count", 64'(op_count_o), 64'(exp_cnt));
      if (rsp_valid_o && q.size() == 0) begin
        chk("spurious_rsp", 64'(rsp_valid_o), 64'd0);
        rsp_ready_i = 1;
      end else if (rsp_valid_o) begin
        if (age == 0) chk("latency", 64'(cyc), 64'(q[0].first));
        else begin
          chk("stable_result", 64'(rsp_result_o), 64'(last_res));
          chk("stable_flag", 64'(rsp_flag_o), 64'(last_flag));
          chk("stable_err", 64'(rsp_err_o), 64'(last_err));
        end
        chk("req_ready_busy", 64'(req_ready_o), 64'd0);
        chk("alu_hold", {alu_op_o, alu_a_o}, {q[0].op, q[0].a});
        last_res = rsp_result_o; last_flag = rsp_flag_o; last_err = rsp_err_o;
        if (age >= q[0].hold) begin
          chk("rsp_result", 64'(rsp_result_o), 64'(q[0].res));
          chk("rsp_flag", 64'(rsp_flag_o), 64'(q[0].flag));
          chk("rsp_err", 64'(rsp_err_o), 64'(q[0].err));
          void'(q.pop_front());
          exp_cnt++;
          age = 0;
          rsp_ready_i = 1;
        end else begin
          age++;
          rsp_ready_i = 0;
        end
      end else begin
        age = 0;
        rsp_ready_i = 1'($urandom);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_i = 0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_op_count", 64'(op_count_o), 64'd0);
    chk("rst_alu", {alu_op_o, alu_b_o, alu_a_o}, 64'd0);
    chk("rst_rsp", {rsp_err_o, rsp_flag_o, rsp_result_o}, 64'd0);
    // Reset during EXEC drops the operation.
    issue(32'd1, 32'd2, 4'b0010, 0);
    reset_i = 1;
    @(posedge clk); #1;
    reset_i = 0;
    repeat (4) @(posedge clk); #1;
    chk("rst_exec_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_exec_ready", 64'(req_ready_o), 64'd1);
    chk("rst_exec_count", 64'(op_count_o), 64'd0);
    // Reset wins over a simultaneous request.
    reset_i = 1; req_valid_i = 1; req_a_i = 32'd7; req_b_i = 32'd9; req_op_i = 4'b0010;
    @(posedge clk); #1;
    reset_i = 0; req_valid_i = 0;
    chk("rst_req_alu_a", 64'(alu_a_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    issue(32'd6, 32'd16, 4'b0010, 0);
    wait_idle();
    chk("add_count", 64'(op_count_o), 64'd1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 5);
    issue(32'd5, 32'd3, 4'b1111, 1);
    issue(32'd3, 32'd5, 4'b0110, 0);
    wait_idle();
    for (int i = 0; i < 40; i++) issue($urandom, $urandom, rnd_op(), $urandom_range(0, 3));
    wait_idle();
    for (int i = 0; i < 400 && exp_cnt != {CW{1'b1}}; i++) begin
      issue($urandom, $urandom, rnd_op(), $urandom_range(0, 1));
      wait_idle();
    end
    chk("pre_wrap", 64'(op_count_o), 64'({CW{1'b1}}));
    issue(32'h80000000, 32'h80000000, 4'b0010, 0);
    wait_idle();
    @(posedge clk); #1;
    chk("wrap", 64'(op_count_o), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
